// File: rtl/vmem_ldst_if.sv
`default_nettype none
// ============================================================================
// Module      : vmem_ldst_if
// Description : Bundle of the command handshake, data-memory port and VRF
//               read/write ports used by the vector load/store sequencer.
//               The sequencer binds to the slave modport; the environment
//               (control FSM, memory, VRF) binds to the master modport.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals (direction as seen by the sequencer / slave):
//   start, op, vreg, base   in   command strobe, 0=load 1=store, reg, lane-0 addr
//   busy, done              out  command in flight, one-cycle completion pulse
//   mem_addr, mem_wdata     out  data-memory address and store byte
//   mem_we                  out  data-memory write enable
//   mem_rdata               in   synchronous-read byte (valid cycle after addr)
//   vreg_sel                out  VRF read select
//   vdata_in                in   VRF asynchronous read data
//   vregw, vdataw, VRFWrite out  VRF write select, data and enable
// ============================================================================
interface vmem_ldst_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              op;
    logic [1:0]        vreg;
    logic [ADDR_W-1:0] base;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic [1:0]        vreg_sel;
    logic [31:0]       vdata_in;
    logic [1:0]        vregw;
    logic [31:0]       vdataw;
    logic              VRFWrite;

    modport slave (
        input  start, op, vreg, base, mem_rdata, vdata_in,
        output busy, done, mem_addr, mem_wdata, mem_we,
               vreg_sel, vregw, vdataw, VRFWrite
    );

    modport master (
        output start, op, vreg, base, mem_rdata, vdata_in,
        input  busy, done, mem_addr, mem_wdata, mem_we,
               vreg_sel, vregw, vdataw, VRFWrite
    );
endinterface
`default_nettype wire

// File: rtl/vmem_ldst.sv
`default_nettype none
// ============================================================================
// Module      : vmem_ldst
// Description : Vector load/store sequencer. Moves a 32-bit vector between one
//               VRF register and four consecutive bytes of the 8-bit data
//               memory (lane k at base+k, little-endian, address wraps).
//               A load fetches four bytes and writes the packed word into the
//               VRF; a store snapshots the register at acceptance and writes
//               its four lanes to memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock   in   all state updates on the rising edge
//   reset   in   synchronous, active-high
//   bus     slave modport of vmem_ldst_if (command, memory and VRF ports)
// Configuration macro:
//   VMEM_STORE_EN  defined   : loads and stores
//                  undefined : loads only; store commands are ignored,
//                              mem_we/mem_wdata/vreg_sel tied to 0
// ============================================================================
module vmem_ldst #(
    parameter int ADDR_W = 8
) (
    input wire        clock,
    input wire        reset,
    vmem_ldst_if.slave bus
);

`ifdef VMEM_STORE_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LCAP  = 3'd2,
        S_LWB   = 3'd3,
        S_STORE = 3'd4,
        S_SDONE = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_LCAP  = 2'd2,
        S_LWB   = 2'd3
    } state_t;
`endif

    state_t            state_q;
    logic [1:0]        k_q;
    logic [1:0]        vreg_q;
    logic [ADDR_W-1:0] base_q;
    logic [23:0]       lbuf_q;      // lanes 0..2 of a load; lane 3 goes straight to vdataw
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [1:0]        vregw_q;
    logic [31:0]       vdataw_q;
    logic              vrfwrite_q;

    // Next lane index and its address; outputs are registered, so every
    // cycle presents the values computed for the following lane.
    logic [1:0]        k_d;
    logic [ADDR_W-1:0] addr_d;

    assign k_d    = k_q + 2'd1;
    assign addr_d = base_q + ADDR_W'(k_d);

`ifdef VMEM_STORE_EN
    logic [31:0]       sbuf_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= 2'd0;
            vreg_q     <= 2'd0;
            base_q     <= '0;
            lbuf_q     <= 24'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
            vregw_q    <= 2'd0;
            vdataw_q   <= 32'd0;
            vrfwrite_q <= 1'b0;
`ifdef VMEM_STORE_EN
            sbuf_q      <= 32'd0;
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
`endif
        end else begin
            // Undriven outputs return to zero; pulses last one cycle.
            done_q     <= 1'b0;
            mem_addr_q <= '0;
            vregw_q    <= 2'd0;
            vdataw_q   <= 32'd0;
            vrfwrite_q <= 1'b0;
`ifdef VMEM_STORE_EN
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.op) begin
                        vreg_q     <= bus.vreg;
                        base_q     <= bus.base;
                        k_q        <= 2'd0;
                        busy_q     <= 1'b1;
                        mem_addr_q <= bus.base;
                        state_q    <= S_LOAD;
                    end
`ifdef VMEM_STORE_EN
                    else if (bus.start && bus.op) begin
                        vreg_q      <= bus.vreg;
                        base_q      <= bus.base;
                        k_q         <= 2'd0;
                        busy_q      <= 1'b1;
                        // Snapshot taken at the acceptance edge, so a VRF
                        // write landing on that same edge is not seen.
                        sbuf_q      <= bus.vdata_in;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= bus.base;
                        mem_wdata_q <= bus.vdata_in[7:0];
                        state_q     <= S_STORE;
                    end
`endif
                end

                S_LOAD: begin
                    // Byte for the address presented last cycle arrives now.
                    case (k_q)
                        2'd1:    lbuf_q[7:0]   <= bus.mem_rdata;
                        2'd2:    lbuf_q[15:8]  <= bus.mem_rdata;
                        2'd3:    lbuf_q[23:16] <= bus.mem_rdata;
                        default: ;
                    endcase
                    if (k_q == 2'd3) begin
                        state_q <= S_LCAP;
                    end else begin
                        k_q        <= k_d;
                        mem_addr_q <= addr_d;
                    end
                end

                S_LCAP: begin
                    vdataw_q   <= {bus.mem_rdata, lbuf_q};
                    vregw_q    <= vreg_q;
                    vrfwrite_q <= 1'b1;
                    done_q     <= 1'b1;
                    state_q    <= S_LWB;
                end

                S_LWB: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

`ifdef VMEM_STORE_EN
                S_STORE: begin
                    if (k_q == 2'd3) begin
                        done_q  <= 1'b1;
                        state_q <= S_SDONE;
                    end else begin
                        k_q         <= k_d;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= sbuf_q[{k_d, 3'b000} +: 8];
                    end
                end

                S_SDONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
`endif

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.vregw    = vregw_q;
    assign bus.vdataw   = vdataw_q;
    assign bus.VRFWrite = vrfwrite_q;

`ifdef VMEM_STORE_EN
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    // Idle: follow the command so the snapshot sees the requested register.
    assign bus.vreg_sel  = (state_q == S_IDLE) ? bus.vreg : vreg_q;
`else
    assign bus.mem_we    = 1'b0;
    assign bus.mem_wdata = 8'd0;
    assign bus.vreg_sel  = 2'd0;

    // VRF read data has no consumer in a load-only build.
    logic w_unused_vdata;
    assign w_unused_vdata = ^bus.vdata_in;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vmem_ldst.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmem_ldst
// Description : Directed self-checking bench for vmem_ldst with a byte memory
//               model (synchronous read) and a four-entry VRF model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmem_ldst;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vmem_ldst_if #(.ADDR_W(ADDR_W)) bus ();

    vmem_ldst #(.ADDR_W(ADDR_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Data memory: synchronous read, bench-side preload port has priority.
    logic [7:0] mem [0:255];
    logic [7:0] rdata_q;
    logic       tb_mem_we;
    logic [7:0] tb_mem_addr;
    logic [7:0] tb_mem_data;

    always @(posedge clk) begin
        if (tb_mem_we)       mem[tb_mem_addr]  <= tb_mem_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rdata_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_q;

    // Vector register file: asynchronous read, DUT write has priority.
    logic [31:0] vrf [0:3];
    logic        tb_vrf_we;
    logic [1:0]  tb_vrf_sel;
    logic [31:0] tb_vrf_data;
    int          vrf_wr_cnt = 0;

    always @(posedge clk) begin
        if (bus.VRFWrite) begin
            vrf[bus.vregw] <= bus.vdataw;
            vrf_wr_cnt     <= vrf_wr_cnt + 1;
        end else if (tb_vrf_we) begin
            vrf[tb_vrf_sel] <= tb_vrf_data;
        end
    end
    assign bus.vdata_in = vrf[bus.vreg_sel];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic poke_mem(input logic [7:0] a, input logic [7:0] d);
        tb_mem_we = 1'b1; tb_mem_addr = a; tb_mem_data = d;
        tick();
        tb_mem_we = 1'b0;
    endtask

    task automatic poke_vrf(input logic [1:0] s, input logic [31:0] d);
        tb_vrf_we = 1'b1; tb_vrf_sel = s; tb_vrf_data = d;
        tick();
        tb_vrf_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_sel;
        rst = 1'b1;
        bus.vreg = 2'd3;
        repeat (2) tick();
`ifdef VMEM_STORE_EN
        exp_sel = 2'd3;
`else
        exp_sel = 2'd0;
`endif
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_tests++; if (bus.VRFWrite !== 1'b0) begin n_fail++; $display("FAIL reset_vrfwrite got=%b exp=0", bus.VRFWrite); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
        n_tests++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=00", bus.mem_addr); end
        n_tests++; if (bus.vdataw !== 32'h0) begin n_fail++; $display("FAIL reset_vdataw got=%h exp=0", bus.vdataw); end
        n_tests++; if (bus.vreg_sel !== exp_sel) begin n_fail++; $display("FAIL reset_vreg_sel got=%0d exp=%0d", bus.vreg_sel, exp_sel); end
        rst = 1'b0;
        bus.vreg = 2'd0;
        tick();
    endtask

    task automatic test_load();
        logic [7:0] exp_addr;
        poke_mem(8'h10, 8'h11); poke_mem(8'h11, 8'h22);
        poke_mem(8'h12, 8'h33); poke_mem(8'h13, 8'h44);
        bus.vreg = 2'd2; bus.base = 8'h10; bus.op = 1'b0; bus.start = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            bus.start = 1'b0;
            exp_addr = (t <= 4) ? 8'(8'h10 + t - 1) : 8'h00;
            n_tests++; if (bus.busy !== (t <= 6)) begin n_fail++; $display("FAIL load_busy T%0d got=%b", t, bus.busy); end
            n_tests++; if (bus.mem_addr !== exp_addr) begin n_fail++; $display("FAIL load_addr T%0d got=%h exp=%h", t, bus.mem_addr, exp_addr); end
            n_tests++; if (bus.done !== (t == 6)) begin n_fail++; $display("FAIL load_done T%0d got=%b", t, bus.done); end
            n_tests++; if (bus.VRFWrite !== (t == 6)) begin n_fail++; $display("FAIL load_vrfwrite T%0d got=%b", t, bus.VRFWrite); end
            n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL load_mem_we T%0d got=%b exp=0", t, bus.mem_we); end
            if (t == 6) begin
                n_tests++; if (bus.vregw !== 2'd2) begin n_fail++; $display("FAIL load_vregw got=%0d exp=2", bus.vregw); end
                n_tests++; if (bus.vdataw !== 32'h44332211) begin n_fail++; $display("FAIL load_vdataw got=%h exp=44332211", bus.vdataw); end
            end
        end
        n_tests++; if (vrf[2] !== 32'h44332211) begin n_fail++; $display("FAIL load_vrf2 got=%h exp=44332211", vrf[2]); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr;
        poke_mem(8'hFE, 8'hA1); poke_mem(8'hFF, 8'hB2);
        poke_mem(8'h00, 8'hC3); poke_mem(8'h01, 8'hD4);
        bus.vreg = 2'd0; bus.base = 8'hFE; bus.op = 1'b0; bus.start = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            bus.start = 1'b0;
            if (t <= 4) begin
                exp_addr = 8'(8'hFE + t - 1);
                n_tests++; if (bus.mem_addr !== exp_addr) begin n_fail++; $display("FAIL wrap_addr T%0d got=%h exp=%h", t, bus.mem_addr, exp_addr); end
            end
            if (t == 6) begin
                n_tests++; if (bus.vdataw !== 32'hD4C3B2A1) begin n_fail++; $display("FAIL wrap_vdataw got=%h exp=d4c3b2a1", bus.vdataw); end
            end
        end
    endtask

    // Second start at T2 of a load must be dropped; a start at T7 is taken.
    task automatic test_back_to_back();
        int         n_done;
        logic [7:0] exp_addr;
        n_done = 0;
        bus.vreg = 2'd1; bus.base = 8'h10; bus.op = 1'b0; bus.start = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (bus.done === 1'b1) n_done++;
            n_tests++; if (bus.busy !== ((t >= 1 && t <= 6) || (t >= 8 && t <= 13))) begin n_fail++; $display("FAIL b2b_busy T%0d got=%b", t, bus.busy); end
            n_tests++; if (bus.done !== (t == 6 || t == 13)) begin n_fail++; $display("FAIL b2b_done T%0d got=%b", t, bus.done); end
            if (t <= 4 || (t >= 8 && t <= 11)) begin
                exp_addr = (t <= 4) ? 8'(8'h10 + t - 1) : 8'(8'h10 + t - 8);
                n_tests++; if (bus.mem_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_addr T%0d got=%h exp=%h", t, bus.mem_addr, exp_addr); end
            end
            case (t)
                1:       bus.start = 1'b0;
                2:       begin bus.start = 1'b1; bus.base = 8'h40; bus.vreg = 2'd3; end
                3:       begin bus.start = 1'b0; bus.base = 8'h10; bus.vreg = 2'd1; end
                7:       bus.start = 1'b1;
                8:       bus.start = 1'b0;
                default: ;
            endcase
        end
        n_tests++; if (n_done != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
        n_tests++; if (vrf[1] !== 32'h44332211) begin n_fail++; $display("FAIL b2b_vrf1 got=%h exp=44332211", vrf[1]); end
    endtask

    task automatic test_reset_abort();
        int wr_before;
        poke_vrf(2'd3, 32'h12345678);
        wr_before = vrf_wr_cnt;
        bus.vreg = 2'd3; bus.base = 8'h10; bus.op = 1'b0; bus.start = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 1) bus.start = 1'b0;
            if (t == 3) rst = 1'b1;
            if (t == 4) begin
                rst = 1'b0;
                n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
            end
            if (t >= 4) begin
                n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done T%0d got=%b exp=0", t, bus.done); end
                n_tests++; if (bus.VRFWrite !== 1'b0) begin n_fail++; $display("FAIL abort_vrfwrite T%0d got=%b exp=0", t, bus.VRFWrite); end
            end
        end
        n_tests++; if (vrf_wr_cnt != wr_before) begin n_fail++; $display("FAIL abort_wr_count got=%0d exp=%0d", vrf_wr_cnt, wr_before); end
        n_tests++; if (vrf[3] !== 32'h12345678) begin n_fail++; $display("FAIL abort_vrf3 got=%h exp=12345678", vrf[3]); end
        bus.start = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            bus.start = 1'b0;
            n_tests++; if (bus.done !== (t == 6)) begin n_fail++; $display("FAIL abort_reload_done T%0d got=%b", t, bus.done); end
        end
        n_tests++; if (vrf[3] !== 32'h44332211) begin n_fail++; $display("FAIL abort_reload_vrf3 got=%h exp=44332211", vrf[3]); end
    endtask

`ifdef VMEM_STORE_EN
    task automatic test_store();
        logic [31:0] word;
        logic [7:0]  exp_b;
        logic [7:0]  exp_addr;
        word = 32'hDEADBEEF;
        poke_vrf(2'd1, word);
        // Same-edge VRF write to the stored register must not be captured.
        tb_vrf_we = 1'b1; tb_vrf_sel = 2'd1; tb_vrf_data = 32'h01020304;
        bus.vreg = 2'd1; bus.base = 8'h20; bus.op = 1'b1; bus.start = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            bus.start = 1'b0; tb_vrf_we = 1'b0;
            n_tests++; if (bus.mem_we !== (t <= 4)) begin n_fail++; $display("FAIL store_we T%0d got=%b", t, bus.mem_we); end
            n_tests++; if (bus.done !== (t == 5)) begin n_fail++; $display("FAIL store_done T%0d got=%b", t, bus.done); end
            n_tests++; if (bus.busy !== (t <= 5)) begin n_fail++; $display("FAIL store_busy T%0d got=%b", t, bus.busy); end
            if (t <= 4) begin
                exp_addr = 8'(8'h20 + t - 1);
                exp_b    = word[8*(t-1) +: 8];
                n_tests++; if (bus.mem_addr !== exp_addr) begin n_fail++; $display("FAIL store_addr T%0d got=%h exp=%h", t, bus.mem_addr, exp_addr); end
                n_tests++; if (bus.mem_wdata !== exp_b) begin n_fail++; $display("FAIL store_wdata T%0d got=%h exp=%h", t, bus.mem_wdata, exp_b); end
                n_tests++; if (bus.vreg_sel !== 2'd1) begin n_fail++; $display("FAIL store_vreg_sel T%0d got=%0d exp=1", t, bus.vreg_sel); end
            end
        end
        n_tests++; if ({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} !== word) begin n_fail++; $display("FAIL store_mem got=%h%h%h%h exp=deadbeef", mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]); end
        n_tests++; if (vrf[1] !== 32'h01020304) begin n_fail++; $display("FAIL store_vrf1 got=%h exp=01020304", vrf[1]); end
        bus.op = 1'b0;
    endtask
`else
    task automatic test_store_disabled();
        bus.vreg = 2'd1; bus.base = 8'h20; bus.op = 1'b1; bus.start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            bus.start = 1'b0;
            n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL nostore_busy T%0d got=%b exp=0", t, bus.busy); end
            n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL nostore_we T%0d got=%b exp=0", t, bus.mem_we); end
            n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL nostore_done T%0d got=%b exp=0", t, bus.done); end
            n_tests++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL nostore_addr T%0d got=%h exp=00", t, bus.mem_addr); end
            n_tests++; if (bus.vreg_sel !== 2'd0) begin n_fail++; $display("FAIL nostore_vreg_sel T%0d got=%0d exp=0", t, bus.vreg_sel); end
        end
        bus.op = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.vreg = 2'd0; bus.base = 8'h00;
        tb_mem_we = 1'b0; tb_mem_addr = 8'h00; tb_mem_data = 8'h00;
        tb_vrf_we = 1'b0; tb_vrf_sel = 2'd0; tb_vrf_data = 32'h0;
        tick();
        test_reset();
        test_load();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
`ifdef VMEM_STORE_EN
        test_store();
`else
        test_store_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
